// File: rtl/first_counter_pkg.sv
// rtl/first_counter_pkg.sv - shared state encoding and defaults for the first_counter family
package first_counter_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_RUN,
    CNT_DONE
  } cnt_state_t;

  localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/first_down_counter.sv
// rtl/first_down_counter.sv - loadable down-counter with sticky underflow flag
// Priority per edge: clear > load > count; AUTO_RELOAD picks one-shot or periodic.
module first_down_counter
  import first_counter_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DEF,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             underflow_pls,
  output logic             busy_out,
  output logic             done_out
);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_uflow;
  logic             r_pls;
  logic             r_busy;
  logic             r_done;

  cnt_state_t       w_nxt_state;
  logic [WIDTH-1:0] w_nxt_count;
  logic [WIDTH-1:0] w_nxt_reload;
  logic             w_nxt_uflow;
  logic             w_nxt_pls;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_count  = r_count;
    w_nxt_reload = r_reload;
    w_nxt_uflow  = r_uflow;
    w_nxt_pls    = 1'b0;
    if (clear) begin
      // reload value deliberately survives a clear
      w_nxt_state = CNT_IDLE;
      w_nxt_count = '0;
      w_nxt_uflow = 1'b0;
    end else if (load) begin
      w_nxt_state  = CNT_RUN;
      w_nxt_count  = load_value;
      w_nxt_reload = load_value;
      w_nxt_uflow  = 1'b0;
    end else if (r_state == CNT_RUN && enable) begin
      if (r_count != '0) begin
        w_nxt_count = r_count - WIDTH'(1);
      end else begin
        w_nxt_uflow = 1'b1;
        w_nxt_pls   = 1'b1;
        if (AUTO_RELOAD) begin
          w_nxt_count = r_reload;
        end else begin
          w_nxt_count = '0;
          w_nxt_state = CNT_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= CNT_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_uflow  <= 1'b0;
      r_pls    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_count  <= w_nxt_count;
      r_reload <= w_nxt_reload;
      r_uflow  <= w_nxt_uflow;
      r_pls    <= w_nxt_pls;
      r_busy   <= (w_nxt_state == CNT_RUN);
      r_done   <= (w_nxt_state == CNT_DONE);
    end
  end

  assign counter_out   = r_count;
  assign underflow_out = r_uflow;
  assign underflow_pls = r_pls;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule

// File: tb/tb_first_down_counter.sv
// tb/tb_first_down_counter.sv - directed self-checking bench for first_down_counter
module tb_first_down_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       clear0 = 1'b0, load0 = 1'b0, en0 = 1'b0;
  logic [3:0] lv0 = 4'd0;
  logic [3:0] cnt0;
  logic       uf0, pls0, busy0, done0;

  logic       clear1 = 1'b0, load1 = 1'b0, en1 = 1'b0;
  logic [3:0] lv1 = 4'd0;
  logic [3:0] cnt1;
  logic       uf1, pls1, busy1, done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  first_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_oneshot (
    .clk(clk), .reset_n(reset_n), .clear(clear0), .load(load0), .load_value(lv0),
    .enable(en0), .counter_out(cnt0), .underflow_out(uf0), .underflow_pls(pls0),
    .busy_out(busy0), .done_out(done0)
  );

  first_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
    .clk(clk), .reset_n(reset_n), .clear(clear1), .load(load1), .load_value(lv1),
    .enable(en1), .counter_out(cnt1), .underflow_out(uf1), .underflow_pls(pls1),
    .busy_out(busy1), .done_out(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [3:0] c, input logic u, input logic p,
                      input logic b, input logic d);
    chk({tag, ".cnt"},  {28'd0, cnt0}, {28'd0, c});
    chk({tag, ".uf"},   {31'd0, uf0},  {31'd0, u});
    chk({tag, ".pls"},  {31'd0, pls0}, {31'd0, p});
    chk({tag, ".busy"}, {31'd0, busy0}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done0}, {31'd0, d});
  endtask

  initial begin
    int exp_cnt [9];
    exp_cnt = '{1, 0, 2, 1, 0, 2, 1, 0, 2};

    // reset state
    #2;
    chk0("rst", 4'd0, 0, 0, 0, 0);
    chk("rst1.cnt", {28'd0, cnt1}, 32'd0);
    chk("rst1.busy", {31'd0, busy1}, 32'd0);
    reset_n = 1'b1;
    tick();

    // one-shot: load 3, enable high
    load0 = 1; lv0 = 4'd3; tick();
    chk0("os_load", 4'd3, 0, 0, 1, 0);
    load0 = 0; en0 = 1;
    tick(); chk0("os_2", 4'd2, 0, 0, 1, 0);
    tick(); chk0("os_1", 4'd1, 0, 0, 1, 0);
    tick(); chk0("os_0", 4'd0, 0, 0, 1, 0);
    tick(); chk0("os_uf", 4'd0, 1, 1, 0, 1);
    tick(); chk0("os_done_hold", 4'd0, 1, 0, 0, 1);

    // sticky cleared by load
    en0 = 0; load0 = 1; lv0 = 4'd7; tick();
    chk0("sticky_load7", 4'd7, 0, 0, 1, 0);
    load0 = 0; clear0 = 1; tick();
    chk0("sticky_clear", 4'd0, 0, 0, 0, 0);
    clear0 = 0;

    // enable ignored in IDLE
    en0 = 1; tick(); tick();
    chk0("idle_en", 4'd0, 0, 0, 0, 0);
    en0 = 0;

    // gating: enable 1,0,1,0
    load0 = 1; lv0 = 4'd4; tick();
    chk0("gate_load", 4'd4, 0, 0, 1, 0);
    load0 = 0;
    en0 = 1; tick(); chk0("gate_e1", 4'd3, 0, 0, 1, 0);
    en0 = 0; tick(); chk0("gate_e0", 4'd3, 0, 0, 1, 0);
    en0 = 1; tick(); chk0("gate_e1b", 4'd2, 0, 0, 1, 0);
    en0 = 0; tick(); chk0("gate_e0b", 4'd2, 0, 0, 1, 0);

    // load 0: first enabled cycle underflows
    load0 = 1; lv0 = 4'd0; tick();
    chk0("zero_load", 4'd0, 0, 0, 1, 0);
    load0 = 0; en0 = 1; tick();
    chk0("zero_uf", 4'd0, 1, 1, 0, 1);
    tick(); tick();
    chk0("done_en", 4'd0, 1, 0, 0, 1);
    en0 = 0;

    // priority: clear beats load
    clear0 = 1; load0 = 1; lv0 = 4'd9; tick();
    chk0("clr_over_load", 4'd0, 0, 0, 0, 0);
    clear0 = 0; lv0 = 4'd1; tick();
    chk0("load1", 4'd1, 0, 0, 1, 0);
    // load beats enable at count 1
    lv0 = 4'd9; en0 = 1; tick();
    chk0("load_over_en", 4'd9, 0, 0, 1, 0);
    load0 = 0; en0 = 0;

    // auto-reload: load 2, enable 9 cycles
    load1 = 1; lv1 = 4'd2; tick();
    chk("ar_load.cnt", {28'd0, cnt1}, 32'd2);
    load1 = 0; en1 = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("ar_%0d.cnt", k), {28'd0, cnt1}, exp_cnt[k-1]);
      chk($sformatf("ar_%0d.pls", k), {31'd0, pls1}, (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("ar_%0d.busy", k), {31'd0, busy1}, 32'd1);
    end
    chk("ar.uf", {31'd0, uf1}, 32'd1);
    chk("ar.done", {31'd0, done1}, 32'd0);

    // auto-reload with reload 0: pulse every enabled cycle
    en1 = 0; load1 = 1; lv1 = 4'd0; tick();
    load1 = 0; en1 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ar0_%0d.pls", k), {31'd0, pls1}, 32'd1);
      chk($sformatf("ar0_%0d.cnt", k), {28'd0, cnt1}, 32'd0);
    end
    en1 = 0; tick();
    chk("ar0_stop.pls", {31'd0, pls1}, 32'd0);

    // async reset mid-run at count 5
    load0 = 1; lv0 = 4'd5; tick();
    load0 = 0;
    chk0("pre_rst", 4'd5, 0, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1 chk0("async_rst", 4'd0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    en0 = 1; tick(); tick();
    chk0("post_rst_idle", 4'd0, 0, 0, 0, 0);
    en0 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
